// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's control, instruction-memory and IF/ID signals.
//
//   Hazard unit -> fetch : StallF, StallD, FlushD
//   Redirects   -> fetch : BranchTakenE/ALUResultE, PCSrcW/ResultW
//   Imem        <-> fetch: PCF (address out), InstrF (read data in)
//   Fetch -> decode/debug: InstrD, PCPlus4D, PCPlus8D, ValidD, FetchFaultD,
//                          FetchCount
//
// Modports:
//   master - the fetch stage itself
//   slave  - the surrounding pipeline / instruction memory
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int CNT_W = 16
) ();
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             BranchTakenE;
    logic [31:0]      ALUResultE;
    logic             PCSrcW;
    logic [31:0]      ResultW;
    logic [31:0]      InstrF;
    logic [31:0]      PCF;
    logic [31:0]      InstrD;
    logic [31:0]      PCPlus4D;
    logic [31:0]      PCPlus8D;
    logic             ValidD;
    logic             FetchFaultD;
    logic [CNT_W-1:0] FetchCount;

    modport master (
        input  StallF, StallD, FlushD, BranchTakenE, ALUResultE,
               PCSrcW, ResultW, InstrF,
        output PCF, InstrD, PCPlus4D, PCPlus8D, ValidD, FetchFaultD, FetchCount
    );

    modport slave (
        output StallF, StallD, FlushD, BranchTakenE, ALUResultE,
               PCSrcW, ResultW, InstrF,
        input  PCF, InstrD, PCPlus4D, PCPlus8D, ValidD, FetchFaultD, FetchCount
    );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Fetch stage of the ARM pipelined processor. Owns the program counter,
// presents a word-aligned fetch address to the instruction memory and
// captures the returned instruction into the IF/ID pipeline register.
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - asynchronous active-low reset
//   fif   - fetch_stage_if.master (hazard controls, redirects, imem, IF/ID)
//
// Parameters:
//   RESET_PC   - PC loaded on reset
//   IMEM_WORDS - number of 32-bit imem words; fetches beyond are flagged
//   CNT_W      - width of the accepted-fetch counter (must match interface)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter int          CNT_W      = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master fif
);

    localparam logic [29:0]      IMEM_LIMIT = 30'(IMEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Program counter
    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [31:0]      pcf_s;
    logic [31:0]      pc_plus4_s;
    logic             fault_s;

    // IF/ID register
    logic [31:0]      instr_q;
    logic [31:0]      instr_d;
    logic [31:0]      p4_q;
    logic [31:0]      p4_d;
    logic [31:0]      p8_q;
    logic [31:0]      p8_d;
    logic             valid_q;
    logic             valid_d;
    logic             fault_q;
    logic             fault_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Imem indexes by address[31:2], so low bits never reach the bus.
    assign pcf_s      = {pc_q[31:2], 2'b00};
    assign pc_plus4_s = pcf_s + 32'd4;
    assign fault_s    = (pcf_s[31:2] >= IMEM_LIMIT);

    // Next-PC selection: execute branch beats writeback PC write beats PC+4.
    always_comb begin
        pc_d = pc_q;
        if (fif.StallF) begin
            pc_d = pc_q;
        end else if (fif.BranchTakenE) begin
            pc_d = fif.ALUResultE;
        end else if (fif.PCSrcW) begin
            pc_d = fif.ResultW;
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // IF/ID next state: flush overrides stall, otherwise capture the fetch.
    // PCPlus8D is kept as its own register so it reads 0 out of reset yet
    // always equals PCPlus4D+4 afterwards (hence 4 on a flushed bubble).
    always_comb begin
        instr_d = instr_q;
        p4_d    = p4_q;
        p8_d    = p8_q;
        valid_d = valid_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        if (fif.FlushD) begin
            instr_d = 32'h0000_0000;
            p4_d    = 32'h0000_0000;
            p8_d    = 32'd4;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (fif.StallD) begin
            instr_d = instr_q;
            p4_d    = p4_q;
            p8_d    = p8_q;
            valid_d = valid_q;
            fault_d = fault_q;
        end else begin
            instr_d = fif.InstrF;
            p4_d    = pc_plus4_s;
            p8_d    = pc_plus4_s + 32'd4;
            valid_d = 1'b1;
            fault_d = fault_s;
            cnt_d   = cnt_q + CNT_ONE;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // IF/ID pipeline register and accepted-fetch counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= 32'h0000_0000;
            p4_q    <= 32'h0000_0000;
            p8_q    <= 32'h0000_0000;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            instr_q <= instr_d;
            p4_q    <= p4_d;
            p8_q    <= p8_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fif.PCF         = pcf_s;
    assign fif.InstrD      = instr_q;
    assign fif.PCPlus4D    = p4_q;
    assign fif.PCPlus8D    = p8_q;
    assign fif.ValidD      = valid_q;
    assign fif.FetchFaultD = fault_q;
    assign fif.FetchCount  = cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the ARM pipelined processor.
- Owns the program counter, drives the word-aligned address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register.
- Obeys stall and flush controls from the hazard unit.
- Redirects on an execute-stage branch and on a writeback-stage PC write.
- Exposes a valid bit and a fetch counter to the decode stage and the debug logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 64, number of 32-bit words in the instruction memory; sets the legal fetch range.
- CNT_W, 16, width of the retired-fetch counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- StallF  in  1  hold PC.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  clear IF/ID register to bubble.
- BranchTakenE  in  1  execute-stage branch redirect.
- ALUResultE  in  32  branch target from execute.
- PCSrcW  in  1  writeback writes PC (R15 destination / BL return).
- ResultW  in  32  PC value from writeback.
- InstrF  in  32  instruction-memory read data for PCF (combinational).
- PCF  out  32  current fetch address to instruction memory.
- InstrD  out  32  IF/ID instruction.
- PCPlus4D  out  32  IF/ID copy of PCF+4.
- PCPlus8D  out  32  PCF+8, the ARM R15 read value for the instruction in decode.
- ValidD  out  1  IF/ID holds a real instruction (0 = bubble).
- FetchFaultD  out  1  IF/ID instruction was fetched from an address outside 0..4*IMEM_WORDS-1.
- FetchCount  out  CNT_W  number of instructions accepted into IF/ID since reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - PCF=RESET_PC.
  - InstrD=0, PCPlus4D=0, PCPlus8D=0.
  - ValidD=0, FetchFaultD=0, FetchCount=0.
  - Reset mid-operation discards all state immediately.
- PCPlus4F = PCF+4, 32-bit wrap, no carry out.
- Next-PC priority:
  - BranchTakenE: ALUResultE.
  - else PCSrcW: ResultW.
  - else PCPlus4F.
  - Redirect selection is combinational and applied on the edge.
- PC register:
  - Loads next-PC each edge unless StallF=1.
  - A redirect coincident with StallF=1 is lost. The hazard unit guarantees StallF=0 whenever BranchTakenE or PCSrcW is asserted, and verification checks this as an assertion.
- PCF bits [1:0] are forced to 0 on output (the instruction memory indexes by a[31:2]). Targets with nonzero low bits are truncated.
- Fault detection:
  - FaultF = (PCF[31:2] >= IMEM_WORDS).
  - Fetch proceeds regardless; the instruction memory result is captured as-is.
- IF/ID register, per edge:
  - FlushD=1 (highest priority, overrides StallD): InstrD=0, ValidD=0, FetchFaultD=0, PCPlus4D=0.
  - else StallD=1: all IF/ID fields hold.
  - else capture: InstrD=InstrF, PCPlus4D=PCPlus4F, ValidD=1, FetchFaultD=FaultF.
- PCPlus8D = PCPlus4D+4 (combinational from the register).
- FetchCount:
  - Increments by 1 on each capture edge (FlushD=0, StallD=0).
  - Wraps from all-ones to 0.
  - Does not increment on flush or stall.
- Latency: one cycle from PCF presentation to InstrD. First valid InstrD appears on the first edge after reset release.
- StallF=1 with StallD=0 is legal: the same PCF is re-fetched and recaptured, and FetchCount increments.
- StallF=0 with StallD=1 is legal: PC advances and the skipped instruction is lost. The hazard unit never issues this combination; verification flags it as a warning.
- No combinational path from InstrF to any output.

Test Plan:
- Reset released, no stalls, memory word k = 32'hE000_0000+k → PCF 0,4,8,12 on successive cycles; InstrD lags by one cycle (E000_0000, E000_0001, …); ValidD=1 from first edge; PCPlus8D=8 when InstrD=E000_0000; FetchCount=4 after four edges.
- StallF=StallD=1 for 3 cycles at PCF=0x10 → PCF, InstrD and FetchCount frozen; released → PCF=0x14 on next edge.
- BranchTakenE=1, ALUResultE=0x40, FlushD=1 in the same cycle → PCF=0x40 next edge; InstrD=0 and ValidD=0 for one cycle; next cycle InstrD=mem[16], ValidD=1.
- PCSrcW=1, ResultW=0x20 with BranchTakenE=1, ALUResultE=0x30 → PCF=0x30 (branch priority). Then PCSrcW alone, ResultW=0x22 → PCF=0x20 (low bits cleared).
- Redirect to 0x100 with IMEM_WORDS=64 → FetchFaultD=1 on the captured instruction; return to 0x0 clears FetchFaultD on the next capture.
- Assert reset mid-stream at PCF=0x2C without a clock edge → PCF=RESET_PC, ValidD=0, FetchCount=0 immediately. With CNT_W=4, 17 captures → FetchCount wraps to 1.
